// File: rtl/uart_defs_pkg.sv
// Shared definitions for uart_frame_gen: FSM state encoding, line idle level
// and the UART_FRAME_LEN(cpb, db, p, sb) frame-length helper macro.
`ifndef UART_DEFS_PKG_SV
`define UART_DEFS_PKG_SV

`define UART_FRAME_LEN(cpb, db, p, sb) ((1 + (db) + (p) + (sb)) * (cpb))

package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; level, full and empty derive
// from the pointer difference (pointers carry one extra wrap bit).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        mem_q <= mem_d;
    end

    assign level = wr_q - rd_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_q == rd_q);
    assign rdata = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_frame_gen.sv
// Queued UART transmitter: FIFO-fed, LSB-first serialiser with registered tx.
// Define UART_FRAME_GEN_PARITY_EN to add the parity bit and parity_odd_i port.
module uart_frame_gen
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
`ifdef UART_FRAME_GEN_PARITY_EN
    input  logic                          parity_odd_i,
`endif
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 wrap, pop, push;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
`ifdef UART_FRAME_GEN_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign push = valid_i && !fifo_full;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (data_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign wrap = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_FRAME_GEN_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                pop = !fifo_empty;
            end
            ST_START: begin
                if (wrap) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (wrap) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_FRAME_GEN_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_FRAME_GEN_PARITY_EN
            ST_PARITY: begin
                if (wrap) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (wrap) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when work is queued.
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            state_d = ST_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
`ifdef UART_FRAME_GEN_PARITY_EN
            par_d   = (^fifo_rdata) ^ parity_odd_i;
`endif
        end

        // tx is registered from the next state so it lines up with state_q.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_FRAME_GEN_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_FRAME_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_FRAME_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = !fifo_full;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_STOP) && wrap && (bit_q == BW'(STOP_BITS - 1));

endmodule
